// File: rtl/sync_shfifo_pkg.sv
// Shared types for the show-ahead FIFO read-side unpacker.
// Optional stall counter is enabled with SHFIFO_UNPACK_STALL_CNT_EN.
package sync_shfifo_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    SEND,
    DONE
  } unpack_state_t;

  localparam int STALL_CNT_W = 16;

endpackage

// File: rtl/sync_shfifo_unpack_rd_shreg.sv
// Word-to-lane shift register: parallel load, right shift by one lane.
// Tracks the current lane and flags the last lane of the word.
module shfifo_unpack_shreg
  import sync_shfifo_pkg::*;
#(
  parameter int IN_WIDTH  = 32,
  parameter int OUT_WIDTH = 8,
  parameter int RATIO     = IN_WIDTH / OUT_WIDTH,
  parameter int LANE_W    = $clog2(RATIO)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic [IN_WIDTH-1:0]  load_data,
  input  logic                 shift,
  output logic [OUT_WIDTH-1:0] lane_data,
  output logic [LANE_W-1:0]    lane,
  output logic                 last_lane
);

  logic [IN_WIDTH-1:0] shreg;

  // Load wins over shift: a reload on the last-lane handshake
  // replaces the exhausted word outright.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg <= '0;
      lane  <= '0;
    end else if (load) begin
      shreg <= load_data;
      lane  <= '0;
    end else if (shift) begin
      shreg <= shreg >> OUT_WIDTH;
      lane  <= lane + LANE_W'(1);
    end
  end

  assign lane_data = shreg[OUT_WIDTH-1:0];
  assign last_lane = (lane == LANE_W'(RATIO - 1));

endmodule

// File: rtl/sync_shfifo_unpack_rd.sv
// Show-ahead FIFO consumer: splits words into LSB-first beats per frame.
// Define SHFIFO_UNPACK_STALL_CNT_EN to add the stall_cnt output.
module sync_shfifo_unpack_rd
  import sync_shfifo_pkg::*;
#(
  parameter int IN_WIDTH  = 32,
  parameter int OUT_WIDTH = 8,
  parameter int RATIO     = IN_WIDTH / OUT_WIDTH,
  parameter int LEN_W     = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [LEN_W-1:0]       frame_len,
  output logic                   busy,
  output logic                   done,
  input  logic [IN_WIDTH-1:0]    fifo_rdat,
  input  logic                   fifo_empty,
  output logic                   fifo_ren,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [OUT_WIDTH-1:0]   m_data,
  output logic                   m_last
`ifdef SHFIFO_UNPACK_STALL_CNT_EN
  ,
  output logic [STALL_CNT_W-1:0] stall_cnt
`endif
);

  localparam int LANE_W = $clog2(RATIO);

  generate
    if (RATIO < 2 || IN_WIDTH != RATIO * OUT_WIDTH) begin : g_bad_cfg
      $error("IN_WIDTH must be RATIO*OUT_WIDTH with RATIO >= 2");
    end
  endgenerate

  unpack_state_t    state, state_nxt;
  logic [LEN_W-1:0] remaining, rem_nxt;
  logic             load, shift;
  logic [LANE_W-1:0] lane;
  logic             last_lane;
  logic             hs;
  logic             rem_one;

  shfifo_unpack_shreg #(
    .IN_WIDTH (IN_WIDTH),
    .OUT_WIDTH(OUT_WIDTH),
    .RATIO    (RATIO),
    .LANE_W   (LANE_W)
  ) u_shreg (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .load_data(fifo_rdat),
    .shift    (shift),
    .lane_data(m_data),
    .lane     (lane),
    .last_lane(last_lane)
  );

  assign m_valid = (state == SEND);
  assign hs      = m_valid && m_ready;
  assign rem_one = (remaining == LEN_W'(1));
  assign m_last  = m_valid && rem_one;
  assign busy    = (state == FETCH) || (state == SEND);
  assign done    = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      remaining <= '0;
    end else begin
      state     <= state_nxt;
      remaining <= rem_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    rem_nxt   = remaining;
    fifo_ren  = 1'b0;
    load      = 1'b0;
    shift     = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          if (frame_len != '0) begin
            rem_nxt   = frame_len;
            state_nxt = FETCH;
          end else begin
            state_nxt = DONE;
          end
        end
      end
      FETCH: begin
        if (!fifo_empty) begin
          fifo_ren  = 1'b1;
          load      = 1'b1;
          state_nxt = SEND;
        end
      end
      SEND: begin
        if (hs) begin
          shift   = 1'b1;
          rem_nxt = remaining - LEN_W'(1);
          // Frame end takes priority; leftover lanes are dropped.
          if (rem_one) begin
            state_nxt = DONE;
          end else if (last_lane) begin
            if (!fifo_empty) begin
              fifo_ren = 1'b1;
              load     = 1'b1;
            end else begin
              state_nxt = FETCH;
            end
          end
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

`ifdef SHFIFO_UNPACK_STALL_CNT_EN
  logic stall;

  assign stall = ((state == FETCH) && fifo_empty) ||
                 ((state == SEND) && !m_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if ((state == IDLE) && start) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + STALL_CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_sync_shfifo_unpack_rd.sv
// Self-checking bench for sync_shfifo_unpack_rd with a FIFO model.
// Works with or without SHFIFO_UNPACK_STALL_CNT_EN defined.
module tb_sync_shfifo_unpack_rd;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] frame_len;
  logic        busy;
  logic        done;
  logic [31:0] fifo_rdat;
  logic        fifo_empty;
  logic        fifo_ren;
  logic        m_valid;
  logic        m_ready;
  logic [7:0]  m_data;
  logic        m_last;
`ifdef SHFIFO_UNPACK_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  int checks;
  int errors;
  int ren_cnt;
  int beats;

  logic [31:0] mem [16];
  int          wp;
  int          rp;

  logic        bp_mode;
  logic [1:0]  bp_idx;
  logic [3:0]  bp_pat;

  logic [8:0]  sb[$];
  logic        done_pend;
  logic        prev_stall;
  logic [7:0]  prev_data;
  logic        prev_last;

  sync_shfifo_unpack_rd dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .frame_len (frame_len),
    .busy      (busy),
    .done      (done),
    .fifo_rdat (fifo_rdat),
    .fifo_empty(fifo_empty),
    .fifo_ren  (fifo_ren),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_last    (m_last)
`ifdef SHFIFO_UNPACK_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Show-ahead FIFO model: head visible while non-empty, pop on ren.
  assign fifo_empty = (wp == rp);
  assign fifo_rdat  = mem[rp[3:0]];

  always @(posedge clk) begin
    if (fifo_ren) rp <= rp + 1;
  end

  // Ready pattern 1,0,0,1 during backpressure, else always ready.
  assign bp_pat  = 4'b1001;
  assign m_ready = bp_mode ? bp_pat[bp_idx] : 1'b1;

  always @(posedge clk) begin
    bp_idx <= bp_idx + 2'd1;
  end

  always @(negedge clk) begin
    logic [8:0] e;
    if (!rst_n) begin
      prev_stall = 1'b0;
      done_pend  = 1'b0;
    end else begin
      if (fifo_ren) begin
        ren_cnt++;
        checks++;
        if (fifo_empty) begin
          errors++;
          $display("FAIL ren_while_empty: fifo_ren=1 with fifo_empty=1");
        end
      end
      if (done_pend) begin
        checks++;
        if (done !== 1'b1) begin
          errors++;
          $display("FAIL done_after_last: got %b want 1", done);
        end
        done_pend = 1'b0;
      end
      if (prev_stall) begin
        checks++;
        if (m_valid !== 1'b1 || m_data !== prev_data ||
            m_last !== prev_last) begin
          errors++;
          $display("FAIL stall_hold: got v=%b d=%h l=%b want v=1 d=%h l=%b",
                   m_valid, m_data, m_last, prev_data, prev_last);
        end
      end
      if (m_valid && m_ready) begin
        beats++;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL extra_beat: got d=%h l=%b want none",
                   m_data, m_last);
        end else begin
          e = sb.pop_front();
          if ({m_last, m_data} !== e) begin
            errors++;
            $display("FAIL beat: got l=%b d=%h want l=%b d=%h",
                     m_last, m_data, e[8], e[7:0]);
          end
          if (m_last) done_pend = 1'b1;
        end
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [31:0] w);
    mem[wp[3:0]] = w;
    wp = wp + 1;
  endtask

  task automatic exp_word(input logic [31:0] w, input int n, input bit last);
    for (int i = 0; i < n; i++) begin
      logic [31:0] s;
      s = w >> (8 * i);
      sb.push_back({last && (i == n - 1), s[7:0]});
    end
  endtask

  task automatic start_frame(input logic [15:0] len);
    frame_len = len;
    start     = 1'b1;
    step();
    start     = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 1;
    while (!done && cyc < 200) begin
      step();
      cyc++;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL timeout: done not seen within %0d cycles", cyc);
    end
  endtask

  task automatic check_sb_empty(input string name);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s: %0d beats missing, want 0", name, sb.size());
    end
  endtask

  task automatic check_int(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || m_valid !== 1'b0 ||
        m_last !== 1'b0 || m_data !== 8'h00 || fifo_ren !== 1'b0) begin
      errors++;
      $display("FAIL reset: got b=%b d=%b v=%b l=%b dat=%h r=%b want 0",
               busy, done, m_valid, m_last, m_data, fifo_ren);
    end
`ifdef SHFIFO_UNPACK_STALL_CNT_EN
    checks++;
    if (stall_cnt !== 16'h0) begin
      errors++;
      $display("FAIL reset_stall_cnt: got %h want 0", stall_cnt);
    end
`endif
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_full_frame();
    int cyc;
    ren_cnt = 0;
    push_word(32'h44332211);
    push_word(32'h88776655);
    exp_word(32'h44332211, 4, 1'b0);
    exp_word(32'h88776655, 4, 1'b1);
    start_frame(16'd8);
    wait_done(cyc);
    check_int("full_latency", cyc, 10);
    check_int("full_ren_cnt", ren_cnt, 2);
    check_sb_empty("full_beats");
    step();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL done_pulse: got done=%b busy=%b want 0 0", done, busy);
    end
  endtask

  task automatic test_partial();
    int cyc;
    ren_cnt = 0;
    push_word(32'hDDCCBBAA);
    push_word(32'h000000EE);
    exp_word(32'hDDCCBBAA, 4, 1'b0);
    exp_word(32'h000000EE, 1, 1'b1);
    start_frame(16'd5);
    wait_done(cyc);
    step();
    check_int("partial_ren_cnt", ren_cnt, 2);
    check_int("partial_fifo_left", wp - rp, 0);
    check_sb_empty("partial_beats");
  endtask

  task automatic test_backpressure();
    int cyc;
    logic [31:0] w0, w1;
    w0 = $urandom;
    w1 = $urandom;
    ren_cnt = 0;
    push_word(w0);
    push_word(w1);
    exp_word(w0, 4, 1'b0);
    exp_word(w1, 4, 1'b1);
    bp_mode = 1'b1;
    start_frame(16'd8);
    wait_done(cyc);
    bp_mode = 1'b0;
    step();
    check_int("bp_ren_cnt", ren_cnt, 2);
    check_sb_empty("bp_beats");
  endtask

  task automatic test_underflow();
    int cyc;
    ren_cnt = 0;
    start_frame(16'd4);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (fifo_ren !== 1'b0 || m_valid !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL underflow_wait: got ren=%b v=%b busy=%b want 0 0 1",
                 fifo_ren, m_valid, busy);
      end
      step();
    end
    push_word(32'hCAFE0B0E);
    exp_word(32'hCAFE0B0E, 4, 1'b1);
    wait_done(cyc);
    step();
    check_int("underflow_ren_cnt", ren_cnt, 1);
    check_sb_empty("underflow_beats");
`ifdef SHFIFO_UNPACK_STALL_CNT_EN
    checks++;
    if (stall_cnt < 16'd5) begin
      errors++;
      $display("FAIL stall_cnt: got %0d want >= 5", stall_cnt);
    end
`endif
  endtask

  task automatic test_zero_and_busy_start();
    int cyc;
    ren_cnt = 0;
    start_frame(16'd0);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || fifo_ren !== 1'b0) begin
      errors++;
      $display("FAIL zero_len: got done=%b busy=%b ren=%b want 1 0 0",
               done, busy, fifo_ren);
    end
    step();
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL zero_len_pulse: got done=%b want 0", done);
    end
    check_int("zero_len_ren", ren_cnt, 0);
    push_word(32'h0D0C0B0A);
    exp_word(32'h0D0C0B0A, 4, 1'b1);
    start_frame(16'd4);
    step();
    start_frame(16'd8);
    wait_done(cyc);
    for (int i = 0; i < 3; i++) step();
    checks++;
    if (busy !== 1'b0 || m_valid !== 1'b0) begin
      errors++;
      $display("FAIL busy_start: got busy=%b v=%b want 0 0", busy, m_valid);
    end
    check_int("busy_start_ren", ren_cnt, 1);
    check_sb_empty("busy_start_beats");
  endtask

  task automatic test_mid_reset();
    int cyc;
    int n;
    ren_cnt = 0;
    beats   = 0;
    push_word(32'h04030201);
    push_word(32'h08070605);
    sb.push_back({1'b0, 8'h01});
    sb.push_back({1'b0, 8'h02});
    start_frame(16'd8);
    n = 0;
    while (beats < 2 && n < 50) begin
      step();
      n++;
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (m_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: got v=%b busy=%b done=%b want 0 0 0",
               m_valid, busy, done);
    end
    check_int("mid_reset_beats", beats, 2);
    step();
    rst_n = 1'b1;
    step();
    step();
    checks++;
    if (busy !== 1'b0 || m_valid !== 1'b0 || fifo_ren !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_idle: got busy=%b v=%b ren=%b want 0 0 0",
               busy, m_valid, fifo_ren);
    end
    ren_cnt = 0;
    exp_word(32'h08070605, 4, 1'b1);
    start_frame(16'd4);
    wait_done(cyc);
    step();
    check_int("post_reset_latency", cyc, 6);
    check_int("post_reset_ren", ren_cnt, 1);
    check_sb_empty("post_reset_beats");
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    ren_cnt    = 0;
    beats      = 0;
    wp         = 0;
    rp         = 0;
    bp_mode    = 1'b0;
    bp_idx     = 2'd0;
    start      = 1'b0;
    frame_len  = '0;
    done_pend  = 1'b0;
    prev_stall = 1'b0;
    prev_data  = '0;
    prev_last  = 1'b0;
    for (int i = 0; i < 16; i++) mem[i] = '0;
    rst_n = 1'b0;
    test_reset();
    test_full_frame();
    test_partial();
    test_backpressure();
    test_underflow();
    test_zero_and_busy_start();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sync_shfifo_unpack_rd.md
Name: sync_shfifo_unpack_rd

Overview:
- Read-side consumer for the team's synchronous show-ahead FIFO.
- Pops IN_WIDTH-bit words using the FIFO's rdat/empty/ren interface and emits them as OUT_WIDTH-bit beats, LSB lane first, on a valid/ready stream.
- Each start command transfers one frame of frame_len beats and marks the final beat with m_last.
- Sits between the FIFO and the narrow downstream datapath (e.g. the byte serializer).

Parameters:
- IN_WIDTH, 32: FIFO word width; must equal the FIFO's FIFO_WIDTH.
- OUT_WIDTH, 8: output beat width; IN_WIDTH must be an integer multiple of it.
- RATIO, IN_WIDTH/OUT_WIDTH: lanes per word; must be at least 2.
- LEN_W, 16: width of frame length in beats.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle frame request; ignored while busy=1
- frame_len  in  LEN_W  frame length in OUT_WIDTH beats; sampled on start
- busy  out  1  frame in progress
- done  out  1  one-cycle pulse at frame end
- fifo_rdat  in  IN_WIDTH  show-ahead head word from the FIFO
- fifo_empty  in  1  FIFO empty
- fifo_ren  out  1  pop the FIFO head (combinational)
- m_valid  out  1  output beat valid
- m_ready  in  1  downstream ready
- m_data  out  OUT_WIDTH  output beat
- m_last  out  1  final beat of the frame

Behaviour:
- Interface decision: reset rst_n, asynchronous, active-low; clock clk.
- Reset values: state IDLE, busy=0, done=0, m_valid=0, m_last=0, m_data=0, shift register=0, remaining=0, lane=0.
- fifo_ren is combinational and is never asserted while fifo_empty=1. One ren cycle pops exactly one word; the word is captured from fifo_rdat in that same cycle.

State machine:
- IDLE:
  - start with frame_len!=0: latch remaining=frame_len, go to FETCH.
  - start with frame_len==0: go to DONE; no FIFO access.
- FETCH:
  - busy=1, m_valid=0.
  - If fifo_empty=0: fifo_ren=1, shreg<=fifo_rdat, lane<=0, go to SEND.
  - Otherwise wait in FETCH.
- SEND:
  - m_valid=1, m_data=shreg[OUT_WIDTH-1:0], m_last=(remaining==1).
  - On m_valid&m_ready: remaining--, shreg shifts right by OUT_WIDTH, lane++.
  - Handshake with remaining==1: go to DONE. Unused upper lanes of the current word are discarded; the word is already popped.
  - Handshake with lane==RATIO-1 and fifo_empty=0: fifo_ren=1, reload shreg, lane<=0, stay in SEND. This gives back-to-back beats with no bubble.
  - Handshake with lane==RATIO-1 and fifo_empty=1: go to FETCH.
  - No handshake: m_data, m_valid and m_last hold stable.
- DONE:
  - done=1 for one cycle, busy=0, then IDLE.
  - start may be accepted in the cycle after done.

Timing:
- start to first m_valid: 2 cycles if the FIFO is non-empty (IDLE→FETCH, FETCH→SEND).
- Steady-state throughput: 1 beat/cycle while the FIFO stays non-empty.

Arithmetic and boundaries:
- remaining is LEN_W bits and never underflows; frame_len=2^LEN_W-1 is legal.
- lane is clog2(RATIO) bits.
- start while busy=1 is dropped with no side effect.
- An asynchronous reset mid-frame returns to IDLE immediately; words already popped are lost. This is accepted behaviour.

Optional Feature:
- Macro: SHFIFO_UNPACK_STALL_CNT_EN.
- When defined:
  - Adds output stall_cnt [15:0].
  - stall_cnt counts cycles spent in FETCH with fifo_empty=1, plus SEND cycles with m_valid&!m_ready.
  - It saturates at 16'hFFFF, clears to 0 on an accepted start, and resets to 0.
- When undefined: the port and its logic are absent, and the remaining behaviour is identical.

Decomposition:
- Package sync_shfifo_pkg holds:
  - typedef enum logic [1:0] {IDLE, FETCH, SEND, DONE} unpack_state_t
  - localparam STALL_CNT_W=16
- Natural sub-module: shfifo_unpack_shreg.
  - Parallel load of IN_WIDTH, shift right by OUT_WIDTH on enable, lane counter, last_lane flag.
  - The top module keeps the FSM, the remaining counter and the FIFO/stream handshakes.

Test Plan:
- Frame with FIFO pre-filled and always-ready sink:
  - Stimulus: FIFO holds 32'h44332211 and 32'h88776655; m_ready=1; start with frame_len=8.
  - Required: m_data is 11,22,33,44,55,66,77,88 on consecutive cycles; m_last only on 88; fifo_ren pulses exactly 2 times; done 1 cycle after the last beat.
- Partial final word:
  - Stimulus: frame_len=5, FIFO holds 32'hDDCCBBAA and 32'h000000EE.
  - Required: beats AA,BB,CC,DD,EE with m_last on EE; 2 words popped; 0 words left in the FIFO.
- Backpressure:
  - Stimulus: m_ready toggled 1,0,0,1 repeatedly during an 8-beat frame.
  - Required: m_data and m_last hold stable during every stall; beat order is unchanged; no duplicate or dropped beats.
- Underflow wait:
  - Stimulus: FIFO empty at start, first word written 5 cycles later.
  - Required: fifo_ren stays 0 and m_valid stays 0 until fifo_empty=0; then normal output; with the macro defined, stall_cnt>=5.
- Zero length and start while busy:
  - Stimulus: start with frame_len=0; then start during an active frame.
  - Required: frame_len=0 gives done in the next cycle with no fifo_ren; the mid-frame start is ignored and the active frame completes unchanged.
- Mid-frame reset:
  - Stimulus: assert rst_n=0 after beat 2 of 8.
  - Required: m_valid, busy and done go to 0 immediately; the FSM is in IDLE after release; a new start runs a clean frame.
